// File: rtl/sched_pkg.sv
// Shared scheduler definitions: FSM state codes, preemption cause codes and
// the default OS handler entry address.
package sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_USER   = 2'd0;
    localparam state_t ST_SWITCH = 2'd1;
    localparam state_t ST_OS     = 2'd2;
    localparam state_t ST_RESUME = 2'd3;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_NONE    = 2'b00;
    localparam cause_t CAUSE_QUANTUM = 2'b01;
    localparam cause_t CAUSE_END     = 2'b10;

    localparam int OS_ENTRY_DEFAULT = 19;

    // end_proc wins when both triggers land in the same cycle
    function automatic cause_t trigger_cause(input logic end_proc, input logic expire);
        if (end_proc)
            return CAUSE_END;
        else if (expire)
            return CAUSE_QUANTUM;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/slice_counter.sv
// Time-slice counter: counts retired instructions, flags quantum expiry and
// saturates at all-ones instead of wrapping.
module slice_counter
    import sched_pkg::*;
#(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_count_en,
    input  logic                 i_clear,
    input  logic [CNT_WIDTH-1:0] i_quantum,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_expire
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_sat;

    assign w_sat   = &r_count;
    // A quantum at or below the running count never matches, so it waits for the next slice
    assign o_expire = i_count_en && (i_quantum != '0)
                      && (r_count == (i_quantum - CNT_WIDTH'(1)));
    assign o_count  = r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_count_en && !w_sat)
            r_count <= r_count + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/quantum_pc_controller.sv
// Round-robin preemption controller: counts retired instructions per slice,
// redirects fetch to the OS handler on expiry/end_proc and back on os_done.
//
// state  | meaning
// USER   | user process running, slice counter active
// SWITCH | one-cycle redirect to OS_ENTRY
// OS     | OS handler running, waits for os_done
// RESUME | one-cycle redirect to latched resume PC
module quantum_pc_controller
    import sched_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int CNT_WIDTH       = 5,
    parameter int QUANTUM_DEFAULT = 20,
    parameter int OS_ENTRY        = OS_ENTRY_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_instr_retire,
    input  logic                 i_end_proc,
    input  logic [PC_WIDTH-1:0]  i_pc_curr,
    input  logic                 i_os_done,
    input  logic [PC_WIDTH-1:0]  i_resume_pc,
    input  logic                 i_quantum_we,
    input  logic [CNT_WIDTH-1:0] i_quantum_in,
    output logic                 o_enable_so,
    output logic [PC_WIDTH-1:0]  o_pc_new,
    output logic                 o_pc_load,
    output logic [PC_WIDTH-1:0]  o_saved_pc,
    output logic [1:0]           o_cause,
    output logic [CNT_WIDTH-1:0] o_slice_count
);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_quantum;
    logic [PC_WIDTH-1:0]   r_saved_pc;
    logic [PC_WIDTH-1:0]   r_resume_pc;
    cause_t                r_cause;

    logic                  w_in_user;
    logic                  w_count_en;
    logic                  w_expire;
    logic                  w_trigger;
    logic                  w_clear;

    assign w_in_user  = (r_state == ST_USER);
    assign w_count_en = w_in_user && i_instr_retire;
    assign w_trigger  = w_in_user && (i_end_proc || w_expire);
    assign w_clear    = w_trigger || !w_in_user;

    slice_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slice_counter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_count_en (w_count_en),
        .i_clear    (w_clear),
        .i_quantum  (r_quantum),
        .o_count    (o_slice_count),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_USER;
            r_quantum   <= CNT_WIDTH'(QUANTUM_DEFAULT);
            r_saved_pc  <= '0;
            r_resume_pc <= '0;
            r_cause     <= CAUSE_NONE;
        end else begin
            if (i_quantum_we)
                r_quantum <= i_quantum_in;
            case (r_state)
                ST_USER: begin
                    if (w_trigger) begin
                        r_state    <= ST_SWITCH;
                        r_saved_pc <= i_pc_curr;
                        r_cause    <= trigger_cause(i_end_proc, w_expire);
                    end
                end
                ST_SWITCH: r_state <= ST_OS;
                ST_OS: begin
                    if (i_os_done) begin
                        r_resume_pc <= i_resume_pc;
                        r_state     <= ST_RESUME;
                    end
                end
                ST_RESUME: begin
                    r_state <= ST_USER;
                    r_cause <= CAUSE_NONE;
                end
                default: r_state <= ST_USER;
            endcase
        end
    end

    // Outputs are gated by reset so an abandoned switch never leaks a redirect
    always_comb begin
        o_enable_so = 1'b0;
        o_pc_load   = 1'b0;
        o_pc_new    = i_pc_curr;
        if (!i_reset) begin
            case (r_state)
                ST_SWITCH: begin
                    o_enable_so = 1'b1;
                    o_pc_load   = 1'b1;
                    o_pc_new    = PC_WIDTH'(OS_ENTRY);
                end
                ST_OS: o_enable_so = 1'b1;
                ST_RESUME: begin
                    o_pc_load = 1'b1;
                    o_pc_new  = r_resume_pc;
                end
                default: ;
            endcase
        end
    end

    assign o_saved_pc = r_saved_pc;
    assign o_cause    = r_cause;

endmodule

// File: doc/quantum_pc_controller.md
QUANTUM_PC_CONTROLLER -- requirements
Module: quantum_pc_controller

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 5, meaning time-slice counter and quantum register width.
REQ-003 The block SHALL have parameter QUANTUM_DEFAULT, default 20, meaning quantum loaded at reset, in retired instructions.
REQ-004 The block SHALL have parameter OS_ENTRY, default 19, meaning OS context-switch handler address.
REQ-005 The block SHALL have port clock, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have ports: instr_retire in 1 (one user instruction retired this cycle); end_proc in 1 (user process finished); pc_curr in PC_WIDTH (sequential next PC from fetch); os_done in 1 (OS handler finished, pulse); resume_pc in PC_WIDTH (PC of next process, sampled with os_done); quantum_we in 1; quantum_in in CNT_WIDTH.
REQ-008 The block SHALL have outputs: enable_so out 1 (OS mode); pc_new out PC_WIDTH (PC to fetch); pc_load out 1 (pc_new is a redirect); saved_pc out PC_WIDTH (preempted process PC); cause out 2 (00 none, 01 quantum, 10 end_proc); slice_count out CNT_WIDTH.

Function
REQ-009 The FSM SHALL have states USER, SWITCH, OS, RESUME; reset state USER.
REQ-010 In USER, slice_count SHALL increment by 1 on each cycle with instr_retire=1 and hold otherwise; enable_so=0, pc_load=0, pc_new=pc_curr.
REQ-011 In USER, quantum expiry SHALL be detected when instr_retire=1 and slice_count==quantum-1, with quantum nonzero.
REQ-012 A quantum register value of 0 SHALL disable preemption; slice_count then saturates at all-ones and never wraps.
REQ-013 In USER, end_proc=1 or quantum expiry SHALL move the FSM to SWITCH next cycle; if both occur together, cause SHALL be 10.
REQ-014 On the USER->SWITCH edge: saved_pc SHALL latch pc_curr, cause SHALL latch the trigger, and slice_count SHALL clear to 0.
REQ-015 SWITCH SHALL last exactly one cycle with enable_so=1, pc_load=1, pc_new=OS_ENTRY, then go to OS.
REQ-016 In OS: enable_so=1, pc_load=0, pc_new=pc_curr, slice_count held at 0, instr_retire and end_proc ignored; stay until os_done=1.
REQ-017 On os_done in OS, the FSM SHALL latch resume_pc and go to RESUME; os_done in any other state SHALL be ignored.
REQ-018 RESUME SHALL last one cycle with enable_so=0, pc_load=1, pc_new=latched resume_pc; next state USER; cause SHALL clear to 00 on exit.
REQ-019 Latency: trigger cycle N -> redirect to OS_ENTRY visible in cycle N+1; os_done cycle M -> redirect to resume_pc in cycle M+1.
REQ-020 quantum_we=1 SHALL load quantum_in in any state; the new value SHALL apply from the next slice (counter not cleared); a write in USER that is at or below the current slice_count SHALL take effect only after the next switch.
REQ-021 saved_pc SHALL hold its value until the next USER->SWITCH edge.

Reset
REQ-022 Reset SHALL force: state USER, slice_count 0, quantum QUANTUM_DEFAULT, saved_pc 0, cause 00, enable_so 0, pc_load 0.
REQ-023 Reset asserted mid-SWITCH/OS/RESUME SHALL abandon the switch with no redirect issued in the following cycle.
REQ-024 Reset SHALL take priority over every input in the same cycle.

Structure
REQ-025 The state enum, cause codes (CAUSE_NONE, CAUSE_QUANTUM, CAUSE_END), and the OS_ENTRY default SHALL reside in a shared package, sched_pkg.
REQ-026 The counter with compare/saturate logic SHALL be one sub-module, slice_counter; the FSM and PC mux SHALL remain in the top module.

Verification
REQ-027 Scenario: reset, then 20 consecutive instr_retire -> SWITCH in the cycle after the 20th retire, pc_new=19, pc_load=1, cause=01, saved_pc=pc_curr.
REQ-028 Scenario: end_proc on the same cycle as the 20th retire -> cause=10, single SWITCH cycle, slice_count=0.
REQ-029 Scenario: os_done with resume_pc=0x400 after 5 OS cycles -> RESUME cycle pc_new=0x400, pc_load=1, enable_so=0; a stray os_done in USER has no effect.
REQ-030 Scenario: quantum_we with quantum_in=3 during OS -> next slice preempts after 3 retires; quantum_in=0 -> 40 retires give no switch and slice_count saturates at 31.
REQ-031 Scenario: reset asserted during OS -> next cycle USER, enable_so=0, quantum=20, no pc_load.
